spi_frame_capture: RTL
======================

Name: spi_frame_capture

Overview:
- Parametrised successor to the single-word SPI deserializer.
- Captures multi-channel sensor frames from an external SPI master in the system clock domain, not the SCK domain.
- Synchronises SCK, CS and MISO, and supports all four CPOL/CPHA modes and either bit order.
- Splits each CS frame into NUM_CH words of DATA_W bits, tags each word with its channel index, and buffers it in a FIFO with a valid/ready interface feeding the filter core.

Parameters:
- DATA_W, 16: bits per channel word (2..32).
- NUM_CH, 1: words per CS frame (1..16).
- FIFO_DEPTH, 4: output FIFO entries (power of 2, >=2).
- CPOL, 0: SCK idle level.
- CPHA, 0: 0 = sample on leading edge, 1 = sample on trailing edge.
- MSB_FIRST, 1: 1 = first bit received lands in bit DATA_W-1; 0 = lands in bit 0.

Ports:
- clk  in  1  system clock; one clock domain.
- rst_n  in  1  asynchronous active-low reset.
- spi_sck  in  1  raw SPI clock from pin, asynchronous to clk.
- spi_cs  in  1  raw chip select, active low, asynchronous.
- spi_miso  in  1  raw serial data, asynchronous.
- out_data  out  DATA_W  FIFO head word.
- out_ch  out  max(1,clog2(NUM_CH))  channel index of head word.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts the head word when high together with out_valid.
- fifo_level  out  clog2(FIFO_DEPTH)+1  current occupancy.
- frame_err  out  1  one-cycle pulse on an aborted or short frame.
- overflow  out  1  sticky flag; a word was dropped because the FIFO was full.
- ovf_clr  in  1  clears overflow.

Behaviour:
- Reset:
  - All outputs are 0.
  - FIFO is empty; counters are 0.
  - Synchroniser flops reset to the idle values: SCK=CPOL, CS=1, MISO=0.
  - State is WAIT_IDLE.
- Input conditioning:
  - Each input passes through a 2-flop synchroniser plus one history flop.
  - An edge is detected when sync stage 2 differs from the history flop.
  - The sample edge is rising SCK when CPOL==CPHA, otherwise falling SCK.
  - Requirement: SCK high and low times are each >= 3 clk periods.
- States:
  - WAIT_IDLE: synchronised CS=1 -> IDLE. Prevents capturing a frame already in progress at reset release.
  - IDLE: CS falling edge -> CAPTURE; bit_cnt=0, ch_cnt=0, shift register cleared.
  - CAPTURE:
    - Each sample edge shifts the synchronised MISO in per MSB_FIRST and increments bit_cnt.
    - On the DATA_W-th bit, {ch_cnt, assembled word} is pushed next cycle, bit_cnt returns to 0 and ch_cnt increments.
    - When the word with ch_cnt==NUM_CH-1 is pushed -> DONE.
    - CS rising edge with any incomplete word or channel -> frame_err pulse. The partial word is discarded, words already pushed remain, and the state goes to IDLE.
  - DONE: sample edges are ignored; CS rising edge -> IDLE.
- A CS rising edge and a sample edge in the same clk cycle: CS wins and the sample edge is ignored.
- Latency: out_valid rises on exactly the 4th rising clk edge after the final sampling SCK edge reaches the pin, measured from an empty FIFO.
- FIFO:
  - First-word-fall-through; out_data and out_ch are registered from storage and are valid whenever out_valid=1.
  - Pop occurs when out_valid && out_ready.
  - A push while full is dropped and sets overflow, unless a pop occurs in the same cycle, in which case both proceed and the level is unchanged.
  - Push and pop in the same cycle at any level: the level is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Head data stays stable while out_valid=1 and out_ready=0.
- overflow clears on ovf_clr; a set event in the same cycle as ovf_clr wins.
- Reset asserted mid-frame: immediate clear of all state as above; the partial frame is lost and no frame_err is generated.

Test Plan:
- Default params, mode 0, MSB first: send 0xA5C3 in one CS frame with out_ready=1 -> one word 0xA5C3, out_ch=0, out_valid high for 1 cycle, 4 clk after the last rising SCK.
- NUM_CH=3, out_ready=0: frame carrying 0x1111, 0x2222, 0x3333 -> fifo_level=3. Then out_ready=1 -> words pop in order with out_ch=0,1,2 and frame_err stays 0.
- CPOL=1, CPHA=1, MSB_FIRST=0: send bits (in time order) 1,0,0,0 then zeros for the rest of a 16-bit word -> out_data=0x0001, sampled on rising SCK edges.
- NUM_CH=2: CS raised after 24 bits -> first word pushed, frame_err pulses once, and the 8-bit partial word is never output.
- FIFO_DEPTH=4, out_ready=0: 5 single-word frames -> fifo_level=4, overflow=1, and the first four words are intact. ovf_clr -> overflow=0.
- rst_n pulsed low while CS is low mid-word, then released with CS still low and SCK toggling -> no words and no frame_err until CS goes high. The next full frame is captured correctly.

Source files
------------

// File: rtl/spi_frame_capture_if.sv
// Output stream of spi_frame_capture: FIFO head word, its channel tag, and a
// valid/ready handshake toward the consumer (the filter core).
//   out_data  : head word, DATA_W bits
//   out_ch    : channel index of the head word
//   out_valid : FIFO holds at least one word
//   out_ready : consumer takes the head word when high together with out_valid
// Modports: master = capture block (producer), slave = consumer.
interface spi_frame_capture_if #(
  parameter int DATA_W = 16,
  parameter int NUM_CH = 1
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [DATA_W-1:0] out_data;
  logic [CH_W-1:0]   out_ch;
  logic              out_valid;
  logic              out_ready;

  modport master (output out_data, output out_ch, output out_valid, input out_ready);
  modport slave  (input out_data, input out_ch, input out_valid, output out_ready);
endinterface

// File: rtl/spi_frame_capture.sv
// SPI slave frame capture in the system clock domain.
// SCK/CS/MISO are synchronised and edge-detected in clk; each CS-low frame is
// split into NUM_CH words of DATA_W bits, tagged with a channel index and
// queued in a first-word-fall-through FIFO.
// Ports:
//   clk, rst_n           : system clock, asynchronous active-low reset
//   spi_sck/cs/miso      : raw asynchronous SPI pins (CS active low)
//   out_if (master)      : out_data / out_ch / out_valid / out_ready stream
//   fifo_level           : FIFO occupancy
//   frame_err            : one-cycle pulse when a frame ends short
//   overflow / ovf_clr   : sticky word-dropped flag and its clear
module spi_frame_capture #(
  parameter int DATA_W     = 16,
  parameter int NUM_CH     = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int CPOL       = 0,
  parameter int CPHA       = 0,
  parameter int MSB_FIRST  = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        spi_sck,
  input  logic                        spi_cs,
  input  logic                        spi_miso,
  spi_frame_capture_if.master         out_if,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        frame_err,
  output logic                        overflow,
  input  logic                        ovf_clr
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BC_W  = $clog2(DATA_W);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [2:0] SCK_RST = {3{CPOL != 0}};

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, CAPTURE, DONE} state_t;

  // [0] = sync stage 1, [1] = sync stage 2, [2] = history
  logic [2:0]        sck_sync_q, sck_sync_d, cs_sync_q, cs_sync_d;
  logic [1:0]        miso_sync_q, miso_sync_d;
  logic [1:0]        flush_q, flush_d;
  state_t            state_q, state_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CH_W-1:0]   ch_cnt_q, ch_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d, shifted;
  logic              push_q, push_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [CH_W-1:0]   wch_q, wch_d;
  logic              frame_err_q, frame_err_d;

  logic [CH_W+DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [CH_W+DATA_W-1:0] head;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]       count_q, count_d;
  logic                   overflow_q, overflow_d;

  logic sck_rise, sck_fall, sample_edge, cs_rise, cs_fall, miso_s;
  logic pop, full, do_push, ovf_set;

  // Input conditioning
  always_comb begin
    sck_sync_d  = {sck_sync_q[1:0], spi_sck};
    cs_sync_d   = {cs_sync_q[1:0], spi_cs};
    miso_sync_d = {miso_sync_q[0], spi_miso};
    // After reset the synchroniser holds idle values, not pin values; wait
    // until every stage has been refilled from the pin before trusting CS.
    flush_d     = (flush_q == 2'd3) ? flush_q : flush_q + 2'd1;
  end

  assign sck_rise    = sck_sync_q[1] & ~sck_sync_q[2];
  assign sck_fall    = ~sck_sync_q[1] & sck_sync_q[2];
  assign cs_rise     = cs_sync_q[1] & ~cs_sync_q[2];
  assign cs_fall     = ~cs_sync_q[1] & cs_sync_q[2];
  assign sample_edge = (CPOL == CPHA) ? sck_rise : sck_fall;
  assign miso_s      = miso_sync_q[1];

  // Frame FSM and word assembly
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    ch_cnt_d    = ch_cnt_q;
    shift_d     = shift_q;
    push_d      = 1'b0;
    word_d      = word_q;
    wch_d       = wch_q;
    frame_err_d = 1'b0;
    if (MSB_FIRST != 0) shifted = {shift_q[DATA_W-2:0], miso_s};
    else                shifted = {miso_s, shift_q[DATA_W-1:1]};

    case (state_q)
      WAIT_IDLE: begin
        if (flush_q == 2'd3 && cs_sync_q[1]) state_d = IDLE;
      end
      IDLE: begin
        if (cs_fall) begin
          state_d   = CAPTURE;
          bit_cnt_d = '0;
          ch_cnt_d  = '0;
          shift_d   = '0;
        end
      end
      CAPTURE: begin
        // CS rising has priority over a coincident sample edge.
        if (cs_rise) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end else if (sample_edge) begin
          shift_d = shifted;
          if (bit_cnt_q == BC_W'(DATA_W - 1)) begin
            push_d    = 1'b1;
            word_d    = shifted;
            wch_d     = ch_cnt_q;
            bit_cnt_d = '0;
            ch_cnt_d  = ch_cnt_q + CH_W'(1);
            if (ch_cnt_q == CH_W'(NUM_CH - 1)) state_d = DONE;
          end else begin
            bit_cnt_d = bit_cnt_q + BC_W'(1);
          end
        end
      end
      DONE: begin
        if (cs_rise) state_d = IDLE;
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  // Output FIFO
  assign pop     = out_if.out_valid && out_if.out_ready;
  assign full    = (count_q == LVL_W'(FIFO_DEPTH));
  assign do_push = push_q && (!full || pop);
  assign ovf_set = push_q && full && !pop;

  always_comb begin
    wr_ptr_d   = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d    = count_q;
    if (do_push && !pop)      count_d = count_q + LVL_W'(1);
    else if (!do_push && pop) count_d = count_q - LVL_W'(1);
    // A set in the same cycle as the clear wins.
    overflow_d = ovf_set | (overflow_q & ~ovf_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_q  <= SCK_RST;
      cs_sync_q   <= 3'b111;
      miso_sync_q <= 2'b00;
      flush_q     <= 2'd0;
      state_q     <= WAIT_IDLE;
      bit_cnt_q   <= '0;
      ch_cnt_q    <= '0;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      sck_sync_q  <= sck_sync_d;
      cs_sync_q   <= cs_sync_d;
      miso_sync_q <= miso_sync_d;
      flush_q     <= flush_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      ch_cnt_q    <= ch_cnt_d;
      push_q      <= push_d;
      frame_err_q <= frame_err_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
    end
  end

  // Data-only storage: qualified by control flops, so no reset needed.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    word_q  <= word_d;
    wch_q   <= wch_d;
    if (do_push) mem_q[wr_ptr_q] <= {wch_q, word_q};
  end

  // Head is read straight from storage; forced to zero while empty.
  assign head             = mem_q[rd_ptr_q];
  assign out_if.out_valid = (count_q != '0);
  assign out_if.out_data  = out_if.out_valid ? head[DATA_W-1:0] : '0;
  assign out_if.out_ch    = out_if.out_valid ? head[CH_W+DATA_W-1:DATA_W] : '0;
  assign fifo_level       = count_q;
  assign frame_err        = frame_err_q;
  assign overflow         = overflow_q;

endmodule
